// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: access-size encodings,
// FSM state encoding and the alignment/legality rule.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // A request faults when its size is illegal or its address is not naturally aligned.
    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] addr_lo);
        logic f;
        case (size)
            SZ_B:    f = 1'b0;
            SZ_H:    f = addr_lo[0];
            SZ_W:    f = (addr_lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response channels and the shared memory port of the LSU.
// Handshake: a request transfers on a rising edge with req_valid && req_ready and a
// response on resp_valid && resp_ready; the sender holds payload stable until then.
interface lsu_ctrl_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_fault;

    logic          mem_en;
    logic          mem_gnt;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_gnt, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_en, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_gnt, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_en, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_sel.sv
// Store lane steering: byte-lane write enables and lane-shifted write data for a
// right-aligned store operand. Purely combinational.
module lsu_lane_sel
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        we_o    = 4'b0000;
        wdata_o = 32'h0;
        case (size_i)
            SZ_B: begin
                we_o    = 4'b0001 << addr_lo_i;
                wdata_o = {24'h0, wdata_i[7:0]} << {addr_lo_i, 3'b000};
            end
            SZ_H: begin
                if (addr_lo_i[1]) begin
                    we_o    = 4'b1100;
                    wdata_o = {wdata_i[15:0], 16'h0};
                end else begin
                    we_o    = 4'b0011;
                    wdata_o = {16'h0, wdata_i[15:0]};
                end
            end
            SZ_W: begin
                we_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                we_o    = 4'b0000;
                wdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: checks alignment, drives one access on
// a shared (stallable) memory port and returns an extended load result or fault.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic        clk,
    input  logic        rst,
    lsu_ctrl_if.slave   bus,
    output lsu_state_e  state_o
);

    lsu_state_e    state_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;

    logic          resp_valid_q;
    logic          resp_fault_q;
    logic [31:0]   resp_rdata_q;
    logic          mem_en_q;
    logic [3:0]    mem_we_q;
    logic [31:0]   mem_wdata_q;

    logic [3:0]    lane_we_d;
    logic [31:0]   lane_wdata_d;
    logic [31:0]   load_ext_d;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          accept;
    logic          req_fault;

    // Lanes are steered from the incoming request so the memory outputs can be registered at accept.
    lsu_lane_sel u_lane_sel (
        .size_i    (bus.req_size),
        .addr_lo_i (bus.req_addr[1:0]),
        .wdata_i   (bus.req_wdata),
        .we_o      (lane_we_d),
        .wdata_o   (lane_wdata_d)
    );

    assign accept    = bus.req_valid && (state_q == ST_IDLE);
    assign req_fault = is_fault(bus.req_size, bus.req_addr[1:0]);

    always_comb begin
        ld_byte    = 8'h0;
        load_ext_d = bus.mem_rdata;
        case (addr_q[1:0])
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            SZ_B:    load_ext_d = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            SZ_H:    load_ext_d = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: load_ext_d = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q        <= bus.req_we;
                        size_q      <= bus.req_size;
                        uns_q       <= bus.req_unsigned;
                        addr_q      <= bus.req_addr;
                        mem_wdata_q <= lane_wdata_d;
                        if (req_fault) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q  <= ST_ISSUE;
                            mem_en_q <= 1'b1;
                            mem_we_q <= bus.req_we ? lane_we_d : 4'b0000;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_gnt) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 4'b0000;
                        if (we_q) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b0;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= load_ext_d;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_fault_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = {addr_q[AW-1:2], 2'b00};
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: request driver, stallable memory responder with a word model,
// and a response consumer checking against expected queues.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int AW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   wdata;
        int            stall;
    } mem_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    lsu_state_e state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [32:0] exp_q[$];
    int          lat_q[$];
    int          rr_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] mem_m [int unsigned];

    mem_exp_t    cur_m;
    logic        in_txn = 1'b0;
    int          wait_cnt = 0;
    logic        pend_v = 1'b0;
    logic [31:0] pend_d = 32'h0;
    logic        seen = 1'b0;
    int          cur_rr = 0;
    int          rr_cnt = 0;

    lsu_ctrl_if #(.AW(AW)) bus ();

    lsu_ctrl #(.AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        int unsigned k;
        k = 32'(a >> 2);
        if (mem_m.exists(k)) return mem_m[k];
        return (k * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic model_fault(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && lo[0]) return 1'b1;
        if (sz == 2'b10 && lo != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lo, input logic uns);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (word >> (8 * int'(lo))) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (word >> (16 * int'(lo[1]))) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic void model_lanes(input logic [1:0] sz, input logic [1:0] lo, input logic [31:0] d,
                                        output logic [3:0] we, output logic [31:0] wd);
        int  base;
        logic hit;
        we = 4'b0;
        wd = 32'h0;
        base = (sz == 2'b00) ? int'(lo) : (sz == 2'b01) ? 2 * int'(lo[1]) : 0;
        for (int i = 0; i < 4; i++) begin
            if (sz == 2'b00)      hit = (i == int'(lo));
            else if (sz == 2'b01) hit = ((i / 2) == int'(lo[1]));
            else                  hit = 1'b1;
            if (hit) begin
                we[i]         = 1'b1;
                wd[8*i +: 8]  = d[8*(i-base) +: 8];
            end
        end
    endfunction

    task automatic send(input logic we, input logic [1:0] sz, input logic uns, input logic [AW-1:0] a,
                        input logic [31:0] d, input int gstall, input int rstall);
        logic        f;
        logic [31:0] r;
        logic [3:0]  lw;
        logic [31:0] ld;
        mem_exp_t    m;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        bus.req_valid    = 1'b1;
        for (int i = 0; i < 200 && !bus.req_ready; i++) @(negedge clk);
        check("req_accept", 64'(bus.req_ready), 64'(1));
        f = model_fault(sz, a[1:0]);
        model_lanes(sz, a[1:0], d, lw, ld);
        r = (f || we) ? 32'h0 : model_load(mem_rd(a), sz, a[1:0], uns);
        exp_q.push_back({f, r});
        lat_q.push_back(cyc + (f ? 1 : ((we ? 2 : 3) + gstall)));
        rr_q.push_back(rstall);
        if (!f) begin
            m.addr  = {a[AW-1:2], 2'b00};
            m.we    = we ? lw : 4'b0000;
            m.wdata = ld;
            m.stall = gstall;
            mem_q.push_back(m);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    // Asserts reset at the current time, holds it for the given number of edges.
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        exp_q.delete();
        lat_q.delete();
        rr_q.delete();
        mem_q.delete();
        in_txn = 1'b0;
        wait_cnt = 0;
        pend_v = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready",  64'(bus.req_ready),  64'(1));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_resp_fault", 64'(bus.resp_fault), 64'(0));
        check("rst_resp_rdata", 64'(bus.resp_rdata), 64'(0));
        check("rst_mem_en",     64'(bus.mem_en),     64'(0));
        check("rst_mem_we",     64'(bus.mem_we),     64'(0));
        check("rst_state",      64'(state),          64'(ST_IDLE));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // Memory responder: grants after the per-access stall, returns read data one cycle later.
    initial begin
        logic [31:0] w;
        bus.mem_gnt   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_gnt   = 1'b0;
            bus.mem_rdata = pend_v ? pend_d : $urandom;
            pend_v        = 1'b0;
            if (bus.mem_en) begin
                if (!in_txn) begin
                    check("mem_expected", 64'(mem_q.size() > 0), 64'(1));
                    if (mem_q.size() > 0) begin
                        cur_m = mem_q.pop_front();
                    end else begin
                        cur_m.addr = bus.mem_addr; cur_m.we = bus.mem_we;
                        cur_m.wdata = bus.mem_wdata; cur_m.stall = 0;
                    end
                    in_txn   = 1'b1;
                    wait_cnt = 0;
                end
                check("mem_addr", 64'(bus.mem_addr), 64'(cur_m.addr));
                check("mem_we",   64'(bus.mem_we),   64'(cur_m.we));
                if (cur_m.we != 4'b0000) check("mem_wdata", 64'(bus.mem_wdata), 64'(cur_m.wdata));
                if (wait_cnt >= cur_m.stall) begin
                    bus.mem_gnt = 1'b1;
                    in_txn      = 1'b0;
                    if (cur_m.we != 4'b0000) begin
                        w = mem_rd(cur_m.addr);
                        for (int i = 0; i < 4; i++)
                            if (cur_m.we[i]) w[8*i +: 8] = cur_m.wdata[8*i +: 8];
                        mem_m[32'(cur_m.addr >> 2)] = w;
                    end else begin
                        pend_d = mem_rd(cur_m.addr);
                        pend_v = 1'b1;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                check("mem_we_idle", 64'(bus.mem_we), 64'(0));
            end
        end
    end

    // Response consumer: latency on first valid, payload every valid cycle, ready after stall.
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.resp_valid && !rst) begin
                check("req_ready_busy", 64'(bus.req_ready), 64'(0));
                if (!seen) begin
                    seen = 1'b1;
                    rr_cnt = 0;
                    check("resp_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (lat_q.size() > 0) begin
                        check("resp_latency", 64'(cyc), 64'(lat_q.pop_front()));
                        cur_rr = rr_q.pop_front();
                    end else begin
                        cur_rr = 0;
                    end
                end
                if (exp_q.size() > 0)
                    check("resp_data", 64'({bus.resp_fault, bus.resp_rdata}), 64'(exp_q[0]));
                if (rr_cnt >= cur_rr) begin
                    bus.resp_ready = 1'b1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    seen = 1'b0;
                end else begin
                    bus.resp_ready = 1'b0;
                    rr_cnt++;
                end
            end else begin
                if (seen) check("resp_dropped", 64'(bus.resp_valid), 64'(1));
                seen = 1'b0;
                bus.resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        logic        we;
        logic [1:0]  sz;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;
        do_reset(3);

        send(1'b1, SZ_B, 1'b0, 32'h1003, 32'h0000_00AB, 0, 0);
        wait_idle();

        mem_m[32'h2000 >> 2] = 32'h8001_1234;
        send(1'b0, SZ_H, 1'b0, 32'h2002, 32'h0, 0, 0);
        send(1'b0, SZ_H, 1'b1, 32'h2002, 32'h0, 0, 0);
        send(1'b0, SZ_B, 1'b0, 32'h2001, 32'h0, 0, 0);
        wait_idle();

        send(1'b0, SZ_W, 1'b0, 32'h3001, 32'h0, 0, 0);
        send(1'b0, SZ_X, 1'b0, 32'h3000, 32'h0, 0, 0);
        send(1'b1, SZ_H, 1'b0, 32'h3003, 32'h1234_5678, 0, 0);
        send(1'b1, SZ_W, 1'b0, 32'h3002, 32'h1234_5678, 0, 0);
        wait_idle();

        send(1'b1, SZ_W, 1'b0, 32'h4000, 32'hDEAD_BEEF, 3, 0);
        send(1'b1, SZ_H, 1'b0, 32'h4006, 32'hCAFE_A5A5, 1, 0);
        send(1'b0, SZ_W, 1'b0, 32'h4004, 32'h0, 2, 0);
        wait_idle();

        send(1'b0, SZ_B, 1'b1, 32'h2001, 32'h0, 0, 2);
        send(1'b0, SZ_W, 1'b0, 32'h4000, 32'h0, 0, 1);
        wait_idle();

        send(1'b0, SZ_W, 1'b0, 32'h5000, 32'h0, 0, 0);
        for (int i = 0; i < 20 && state != ST_RDWAIT; i++) @(negedge clk);
        check("reach_rdwait", 64'(state), 64'(ST_RDWAIT));
        do_reset(1);
        repeat (4) @(negedge clk);
        check("no_resp_after_rst", 64'(bus.resp_valid), 64'(0));
        send(1'b0, SZ_W, 1'b0, 32'h5000, 32'h0, 0, 0);
        wait_idle();

        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            send(we, sz, 1'($urandom_range(0, 1)), 32'h6000 + 32'($urandom_range(0, 31)),
                 $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: AW, 32, byte address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  pipeline load/store request.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  zero-extend load result (LBU/LHU).
REQ-009 req_addr  in  AW  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  response consumed when resp_valid && resp_ready.
REQ-013 resp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-014 resp_fault  out  1  misaligned or illegal-size request.
REQ-015 mem_en  out  1  memory port request.
REQ-016 mem_gnt  in  1  port granted this cycle (port is shared; may stall).
REQ-017 mem_addr  out  AW  word address {req_addr[AW-1:2],2'b00}.
REQ-018 mem_we  out  4  byte-lane write enables; 0000 for loads.
REQ-019 mem_wdata  out  32  lane-shifted store data.
REQ-020 mem_rdata  in  32  read word, valid the cycle after a granted load.

Function
REQ-021 FSM states: IDLE, ISSUE, RDWAIT, RESP; req_ready = (state==IDLE).
REQ-022 IDLE + accept: latch we/size/unsigned/addr/wdata; aligned legal -> ISSUE; else -> RESP with fault.
REQ-023 Fault conditions: size 11; half with addr[0]=1; word with addr[1:0]!=00; no memory access issued.
REQ-024 ISSUE: mem_en=1, mem_addr/mem_we/mem_wdata driven from latched request; held stable until mem_gnt.
REQ-025 ISSUE + mem_gnt: store -> RESP; load -> RDWAIT; without mem_gnt stay in ISSUE.
REQ-026 RDWAIT: capture extended mem_rdata into resp_rdata, -> RESP (exactly one cycle).
REQ-027 RESP: resp_valid=1, outputs stable until resp_ready; on resp_ready -> IDLE.
REQ-028 Store lanes: word 1111 data as-is; half addr[1]=0 -> 0011 {16'b0,d[15:0]}, addr[1]=1 -> 1100 {d[15:0],16'b0}; byte addr[1:0]=n -> lane n only, d[7:0] shifted by 8n, other bits 0.
REQ-029 Load extract: byte = lane addr[1:0], half = halfword addr[1]; sign-extend from bit 7/15 unless unsigned; word unchanged.
REQ-030 Zero-stall latency from accept cycle T: store resp_valid at T+2, load at T+3, fault at T+1.
REQ-031 One outstanding request; no new acceptance before RESP handshake completes.
REQ-032 mem_en=0 and mem_we=0000 in every state except ISSUE.

Reset
REQ-033 On rst: state IDLE, resp_valid=0, resp_fault=0, resp_rdata=0, mem_en=0, mem_we=0000, latched request cleared; req_ready=1 the cycle after.
REQ-034 rst mid-operation abandons the request: no response, mem_en low next cycle, no pending write.

Structure
REQ-035 Shared package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), FSM state encoding.
REQ-036 Sub-module lsu_lane_sel: combinational store lane/shift per REQ-028; load extract stays in lsu_ctrl.

Verification
REQ-037 Store byte addr 0x1003, wdata 0x000000AB, gnt=1 -> ISSUE mem_addr 0x1000, mem_we 1000, mem_wdata 0xAB000000; resp at T+2, rdata 0.
REQ-038 Load half signed addr 0x2002, mem_rdata 0x8001_1234 -> resp_rdata 0xFFFF8001 at T+3; unsigned -> 0x00008001.
REQ-039 Load word addr 0x3001 -> resp_fault=1 at T+1, mem_en never asserted.
REQ-040 Store word with mem_gnt low 3 cycles -> mem_en/addr/we/wdata stable throughout, resp 1 cycle after grant.
REQ-041 resp_ready low 2 cycles in RESP -> resp_valid/rdata held, req_ready=0 until handshake.
REQ-042 rst asserted in RDWAIT -> no resp_valid, req_ready=1 next cycle, next request completes normally.
